// File: rtl/avg_pool_sched_if.sv
// avg_pool_sched_if: start/status, activation read, pool feed and
// output write signals of the average-pool sequencer.
interface avg_pool_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int CH_WIDTH   = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CH_WIDTH-1:0]   num_channels;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  pool_valid;
    logic [DATA_WIDTH-1:0] pool_data;
    logic                  pool_done;
    logic [DATA_WIDTH-1:0] pool_average;
    logic                  wr_en;
    logic [CH_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  error;

    modport master (
        input  start, base_addr, num_channels, rd_data,
        input  pool_done, pool_average,
        output busy, done, rd_en, rd_addr, pool_valid, pool_data,
        output wr_en, wr_addr, wr_data, error
    );

    modport slave (
        output start, base_addr, num_channels, rd_data,
        output pool_done, pool_average,
        input  busy, done, rd_en, rd_addr, pool_valid, pool_data,
        input  wr_en, wr_addr, wr_data, error
    );
endinterface

// File: rtl/avg_pool_sched.sv
// avg_pool_sched: walks channels, feeds avg_pool, writes one average per channel.
// Optional WAIT_DONE watchdog: define AVG_POOL_SCHED_TIMEOUT_EN.
module avg_pool_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int CH_WIDTH   = 10,
    parameter int POINTS     = 49
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic             clock,
    input  logic             reset,
    avg_pool_sched_if.master bus
);
    localparam int PT_W = $clog2(POINTS + 1);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT_DONE,
        WRITE,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CH_WIDTH-1:0]   limit_q, limit_d;
    logic [CH_WIDTH-1:0]   ch_idx_q, ch_idx_d;
    logic [PT_W-1:0]       pt_q, pt_d;
    logic [DATA_WIDTH-1:0] avg_q, avg_d;
    logic                  pool_valid_q, pool_valid_d;
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]       to_q, to_d;
    logic                  error_q, error_d;
`endif

    // Next-state and datapath update for the channel sequencer
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        limit_d      = limit_q;
        ch_idx_d     = ch_idx_q;
        pt_d         = pt_q;
        avg_d        = avg_q;
        pool_valid_d = (state_q == STREAM);
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
        to_d         = '0;
        error_d      = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    limit_d  = bus.num_channels;
                    ch_idx_d = '0;
                    pt_d     = '0;
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
                    error_d  = 1'b0;
`endif
                    state_d  = (bus.num_channels == '0) ? FINISH : STREAM;
                end
            end
            STREAM: begin
                // address keeps running across channels: layout is contiguous
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (pt_q == PT_W'(POINTS - 1)) begin
                    pt_d    = '0;
                    state_d = WAIT_DONE;
                end else begin
                    pt_d = pt_q + PT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.pool_done) begin
                    avg_d   = bus.pool_average;
                    state_d = WRITE;
                end
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    avg_d   = '0;
                    error_d = 1'b1;
                    state_d = WRITE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
`endif
            end
            WRITE: begin
                if (ch_idx_q == limit_q - CH_WIDTH'(1)) begin
                    state_d = FINISH;
                end else begin
                    ch_idx_d = ch_idx_q + CH_WIDTH'(1);
                    state_d  = STREAM;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            limit_q      <= '0;
            ch_idx_q     <= '0;
            pt_q         <= '0;
            avg_q        <= '0;
            pool_valid_q <= 1'b0;
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
            to_q         <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            limit_q      <= limit_d;
            ch_idx_q     <= ch_idx_d;
            pt_q         <= pt_d;
            avg_q        <= avg_d;
            pool_valid_q <= pool_valid_d;
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
            to_q         <= to_d;
            error_q      <= error_d;
`endif
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == FINISH);
    assign bus.rd_en      = (state_q == STREAM);
    assign bus.rd_addr    = addr_q;
    assign bus.pool_valid = pool_valid_q;
    // read data is forwarded in its arrival cycle; zero when not valid
    assign bus.pool_data  = pool_valid_q ? bus.rd_data : '0;
    assign bus.wr_en      = (state_q == WRITE);
    assign bus.wr_addr    = ch_idx_q;
    assign bus.wr_data    = avg_q;
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
    assign bus.error      = error_q;
`else
    assign bus.error      = 1'b0;
`endif
endmodule

// File: tb/tb_avg_pool_sched.sv
// tb_avg_pool_sched: randomized scoreboard bench for avg_pool_sched
// with POINTS=4 and a behavioural avg_pool model.
module tb_avg_pool_sched;
    localparam int POINTS = 4;
    localparam int TMO    = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    avg_pool_sched_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .CH_WIDTH(10)) bus ();

    avg_pool_sched #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .CH_WIDTH(10),
        .POINTS(POINTS)
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] mem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          done_cyc = 0;
    int          wr_seen = 0;
    int          rd_run = 0;
    int          pv_run = 0;
    bit          never_done = 1'b0;

    logic [15:0] exp_rd [$];
    logic [31:0] exp_pd [$];
    logic [9:0]  exp_wa [$];
    logic [31:0] exp_wd [$];
    int          exp_done = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // activation buffer: one-cycle read latency
    always @(posedge clock)
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    // avg_pool model: done two cycles after the POINTS-th valid
    longint psum = 0;
    int     pcnt = 0;
    bit     pend = 1'b0;
    always @(posedge clock) begin
        if (reset) begin
            psum <= 0;
            pcnt <= 0;
            pend <= 1'b0;
            bus.pool_done <= 1'b0;
        end else begin
            bus.pool_done <= pend && !never_done;
            pend <= 1'b0;
            if (bus.pool_valid) begin
                if (pcnt == POINTS - 1) begin
                    pend <= 1'b1;
                    pcnt <= 0;
                    psum <= 0;
                    bus.pool_average <= 32'((psum + longint'(bus.pool_data)) / POINTS);
                end else begin
                    pcnt <= pcnt + 1;
                    psum <= psum + longint'(bus.pool_data);
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents an event
    always @(negedge clock) begin
        if (reset) begin
            rd_run = 0;
            pv_run = 0;
        end else begin
            if (bus.rd_en) begin
                rd_run++;
                if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", bus.rd_addr, exp_rd.pop_front());
            end else if (rd_run != 0) begin
                check("rd_burst_len", rd_run, POINTS);
                rd_run = 0;
            end
            if (bus.pool_valid) begin
                pv_run++;
                if (exp_pd.size() == 0) check("pool_unexpected", 1, 0);
                else check("pool_data", bus.pool_data, exp_pd.pop_front());
            end else if (pv_run != 0) begin
                check("pool_burst_len", pv_run, POINTS);
                pv_run = 0;
            end
            if (bus.wr_en) begin
                wr_seen++;
                if (exp_wa.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    check("wr_addr", bus.wr_addr, exp_wa.pop_front());
                    check("wr_data", bus.wr_data, exp_wd.pop_front());
                end
            end
            if (bus.done) begin
                done_seen++;
                done_cyc = cyc;
                if (exp_done == 0) check("done_unexpected", 1, 0);
                else exp_done--;
            end
        end
    end

    task automatic clear_sb();
        exp_rd.delete();
        exp_pd.delete();
        exp_wa.delete();
        exp_wd.delete();
        exp_done = 0;
        done_seen = 0;
        wr_seen = 0;
    endtask

    task automatic expect_run(input logic [15:0] base, input int n, input bit tmo);
        logic [15:0] a;
        longint s;
        a = base;
        for (int c = 0; c < n; c++) begin
            s = 0;
            for (int p = 0; p < POINTS; p++) begin
                exp_rd.push_back(a);
                exp_pd.push_back(mem[a]);
                s += longint'(mem[a]);
                a = a + 16'd1;
            end
            exp_wa.push_back(10'(c));
            exp_wd.push_back(tmo ? 32'd0 : 32'(s / POINTS));
        end
        exp_done++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_pool_valid"}, bus.pool_valid, 0);
        check({tag, "_pool_data"}, bus.pool_data, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_error"}, bus.error, 0);
    endtask

    task automatic issue_start(input logic [15:0] base, input int n, output int st);
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.num_channels = 10'(n);
        st = cyc;
    endtask

    task automatic wait_done(input int st, input int lat, input bit spam);
        int k;
        k = 0;
        while (done_seen == 0 && k < 3000) begin
            @(posedge clock); #1;
            bus.start = spam ? bus.busy : 1'b0;
            if (spam) begin
                bus.base_addr = 16'($urandom);
                bus.num_channels = 10'($urandom);
            end
            k++;
        end
        bus.start = 1'b0;
        check("done_seen", done_seen, 1);
        check("done_latency", done_cyc - st, lat);
        repeat (2) @(posedge clock);
        #1;
        check("busy_after", bus.busy, 0);
        check("done_count", done_seen, 1);
        check("rd_left", exp_rd.size(), 0);
        check("pool_left", exp_pd.size(), 0);
        check("wr_left", exp_wa.size(), 0);
        check("done_left", exp_done, 0);
    endtask

    task automatic run(input logic [15:0] base, input int n, input bit spam);
        int st;
        clear_sb();
        expect_run(base, n, 1'b0);
        issue_start(base, n, st);
        wait_done(st, 1 + n * (POINTS + 4), spam);
    endtask

    task automatic fill_rand(input logic [15:0] base, input int n);
        logic [15:0] a;
        a = base;
        for (int i = 0; i < n * POINTS; i++) begin
            mem[a] = $urandom;
            a = a + 16'd1;
        end
    endtask

    initial begin
        int st;
        int k;
        logic [15:0] b;
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_channels = '0;
        bus.rd_data = '0;
        bus.pool_average = '0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;

        for (int p = 0; p < POINTS; p++) mem[16'h100 + p] = 32'(p + 1);
        run(16'h0100, 1, 1'b0);

        for (int c = 0; c < 3; c++)
            for (int p = 0; p < POINTS; p++)
                mem[16'h100 + c * POINTS + p] = 32'(4 * (c + 1));
        run(16'h0100, 3, 1'b0);
        run(16'h0100, 0, 1'b0);
        run(16'h0100, 3, 1'b1);

        clear_sb();
        expect_run(16'h0100, 3, 1'b0);
        issue_start(16'h0100, 3, st);
        k = 0;
        while (wr_seen == 0 && k < 200) begin
            @(posedge clock); #1;
            bus.start = 1'b0;
            k++;
        end
        check("ch1_streaming", bus.rd_en, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_zero("midreset");
        clear_sb();
        fill_rand(16'h0100, 2);
        run(16'h0100, 2, 1'b0);

        for (int r = 0; r < 6; r++) begin
            b = (r % 3 == 0) ? 16'hFFFA : 16'($urandom);
            n = $urandom_range(0, 5);
            fill_rand(b, n);
            run(b, n, 1'($urandom_range(0, 1)));
        end

        never_done = 1'b1;
        clear_sb();
        fill_rand(16'h0200, 1);
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
        expect_run(16'h0200, 1, 1'b1);
        issue_start(16'h0200, 1, st);
        wait_done(st, 1 + POINTS + TMO + 1, 1'b0);
        check("timeout_error", bus.error, 1);
`else
        expect_run(16'h0200, 1, 1'b0);
        exp_wa.delete();
        exp_wd.delete();
        exp_done = 0;
        issue_start(16'h0200, 1, st);
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("stuck_busy", bus.busy, 1);
        check("stuck_error", bus.error, 0);
        check("stuck_no_write", wr_seen, 0);
        check("stuck_rd_left", exp_rd.size(), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_zero("stuck_reset");
`endif
        never_done = 1'b0;
        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
